// File: rtl/clk_div_ramp_pkg.sv
// Shared types for the clock-divider ramp controller.
// Holds the FSM state type and the default divide-value type.
package clk_div_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DWELL,
        DONE
    } ramp_state_e;

    localparam int unsigned DIV_W_DFLT = 4;

    typedef logic [DIV_W_DFLT-1:0] div_val_t;

endpackage

// File: rtl/clk_div_ramp_if.sv
// Bundle between the controller, its requester and the divider.
// Ports: target request (tgt_*), abort_i, divider handshake (div_*), status.
interface clk_div_ramp_if #(
    parameter int DIV_VALUE_WIDTH = 4,
    parameter int DWELL_WIDTH     = 8
);

    logic [DIV_VALUE_WIDTH-1:0] tgt_div_i;
    logic [DIV_VALUE_WIDTH-1:0] step_i;
    logic [DWELL_WIDTH-1:0]     dwell_i;
    logic                       tgt_valid_i;
    logic                       tgt_ready_o;
    logic                       abort_i;
    logic [DIV_VALUE_WIDTH-1:0] div_o;
    logic                       div_valid_o;
    logic                       div_ready_i;
    logic [DIV_VALUE_WIDTH-1:0] cur_div_o;
    logic                       busy_o;
    logic                       done_o;

    modport slave (
        input  tgt_div_i, step_i, dwell_i, tgt_valid_i,
        input  abort_i, div_ready_i,
        output tgt_ready_o, div_o, div_valid_o,
        output cur_div_o, busy_o, done_o
    );

    modport master (
        output tgt_div_i, step_i, dwell_i, tgt_valid_i,
        output abort_i, div_ready_i,
        input  tgt_ready_o, div_o, div_valid_o,
        input  cur_div_o, busy_o, done_o
    );

endinterface

// File: rtl/clk_div_step_calc.sv
// Next divide value toward a target, moving at most stp per step.
// Ports: cur_i, tgt_i, stp_i (inputs), next_o (never overshoots tgt_i).
module clk_div_step_calc #(
    parameter int W = 4
) (
    input  logic [W-1:0] cur_i,
    input  logic [W-1:0] tgt_i,
    input  logic [W-1:0] stp_i,
    output logic [W-1:0] next_o
);

    logic [W:0] cur_x;
    logic [W:0] tgt_x;
    logic [W:0] stp_x;
    logic [W:0] sum;
    logic [W:0] gap;

    always_comb begin
        cur_x  = {1'b0, cur_i};
        tgt_x  = {1'b0, tgt_i};
        stp_x  = {1'b0, stp_i};
        // One extra bit so cur + stp cannot wrap past the target.
        sum    = cur_x + stp_x;
        gap    = cur_x - tgt_x;
        next_o = tgt_i;
        if (tgt_x > cur_x) begin
            next_o = (sum > tgt_x) ? tgt_i : sum[W-1:0];
        end else if (cur_x > tgt_x) begin
            next_o = (gap <= stp_x) ? tgt_i : (cur_i - stp_i);
        end
    end

endmodule

// File: rtl/clk_div_ramp_ctrl.sv
// Walks the clock divider toward a requested divide value in bounded steps.
// Ports: clk_i, rst_i (sync, active-high), bus (request, divider handshake, status).
module clk_div_ramp_ctrl
    import clk_div_ramp_pkg::*;
#(
    parameter int DIV_VALUE_WIDTH   = 4,
    parameter int DEFAULT_DIV_VALUE = 2,
    parameter int DWELL_WIDTH       = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    clk_div_ramp_if.slave  bus
);

    localparam int W = DIV_VALUE_WIDTH;

    typedef logic [W-1:0]           dv_t;
    typedef logic [DWELL_WIDTH-1:0] dw_t;

    localparam dv_t DEF_DIV = dv_t'(DEFAULT_DIV_VALUE);

    ramp_state_e state_q, state_d;
    dv_t         cur_q, cur_d;
    dv_t         div_q, div_d;
    dv_t         tgt_q, tgt_d;
    dv_t         stp_q, stp_d;
    dw_t         dwell_q, dwell_d;
    dw_t         cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        valid_q, valid_d;

    dv_t  tgt_in;
    dv_t  stp_in;
    dv_t  calc_cur;
    dv_t  calc_tgt;
    dv_t  calc_stp;
    dv_t  next_div;
    logic accept;
    logic hs;

    // Zero requests are meaningless for a divider; treat them as 1.
    assign tgt_in = (bus.tgt_div_i == '0) ? dv_t'(1) : bus.tgt_div_i;
    assign stp_in = (bus.step_i == '0) ? dv_t'(1) : bus.step_i;

    assign accept = bus.tgt_valid_i && (state_q == IDLE);
    assign hs     = valid_q && bus.div_ready_i;

    // In IDLE the fresh request feeds the calculator; in ISSUE the value
    // being handed over becomes the new current one, so step from it.
    always_comb begin
        calc_cur = (state_q == ISSUE) ? div_q : cur_q;
        calc_tgt = (state_q == IDLE) ? tgt_in : tgt_q;
        calc_stp = (state_q == IDLE) ? stp_in : stp_q;
    end

    clk_div_step_calc #(
        .W (W)
    ) u_step_calc (
        .cur_i  (calc_cur),
        .tgt_i  (calc_tgt),
        .stp_i  (calc_stp),
        .next_o (next_div)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        div_d   = div_q;
        tgt_d   = tgt_q;
        stp_d   = stp_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d   = tgt_in;
                    stp_d   = stp_in;
                    dwell_d = bus.dwell_i;
                    if (tgt_in == cur_q) begin
                        state_d = DONE;
                    end else begin
                        div_d   = next_div;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.abort_i) begin
                    abort_d = 1'b1;
                end
                if (hs) begin
                    cur_d = div_q;
                    if (div_q == tgt_q) begin
                        state_d = DONE;
                    end else if (abort_q || bus.abort_i) begin
                        state_d = IDLE;
                    end else if (dwell_q == '0) begin
                        div_d   = next_div;
                        state_d = ISSUE;
                    end else begin
                        cnt_d   = dwell_q;
                        state_d = DWELL;
                    end
                end
            end
            DWELL: begin
                if (bus.abort_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q <= dw_t'(1)) begin
                    cnt_d   = '0;
                    div_d   = next_div;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q - dw_t'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            abort_d = 1'b0;
        end
        valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cur_q   <= DEF_DIV;
            div_q   <= DEF_DIV;
            tgt_q   <= DEF_DIV;
            stp_q   <= dv_t'(1);
            dwell_q <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            div_q   <= div_d;
            tgt_q   <= tgt_d;
            stp_q   <= stp_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
        end
    end

    assign bus.div_o       = div_q;
    assign bus.div_valid_o = valid_q;
    assign bus.cur_div_o   = cur_q;
    assign bus.tgt_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Scoreboard bench for clk_div_ramp_ctrl: directed cases plus random ramps.
// Expected steps come from an arithmetic model; a monitor checks the divider side.
module tb_clk_div_ramp_ctrl;

    localparam int DEF = 2;

    typedef struct {
        int v;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_bit = 1'b1;
    logic mon_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int m_cur = DEF;
    int mon_cur = DEF;
    int low_cnt = 0;
    bit prev_stall = 0;
    bit prev_done = 0;
    int prev_div = 0;
    bit flag;

    exp_t exp_q[$];
    int   exp_done[$];

    clk_div_ramp_if #(.DIV_VALUE_WIDTH(4), .DWELL_WIDTH(8)) bus ();

    clk_div_ramp_ctrl #(
        .DIV_VALUE_WIDTH   (4),
        .DEFAULT_DIV_VALUE (DEF),
        .DWELL_WIDTH       (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    assign bus.div_ready_i = rand_rdy ? rnd_bit : rdy_force;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input int act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected none at %0t", name, act, $time);
    endtask

    // Reference ramp: pushes every step the divider should accept.
    task automatic plan(input int t, input int s, input int d, input int maxn);
        int tg;
        int st;
        int c;
        int n;
        exp_t e;
        tg = (t == 0) ? 1 : t;
        st = (s == 0) ? 1 : s;
        c  = m_cur;
        n  = 0;
        while (c != tg && n < maxn) begin
            if (tg > c) c = (c + st > tg) ? tg : c + st;
            else        c = (c - tg <= st) ? tg : c - st;
            e.v   = c;
            e.gap = (n == 0) ? -1 : d;
            exp_q.push_back(e);
            n++;
        end
        if (c == tg) exp_done.push_back(tg);
        m_cur = c;
    endtask

    task automatic req(input int t, input int s, input int d,
                       input int maxn, output bit after_done);
        bit last_done;
        int n;
        last_done = 0;
        n = 0;
        plan(t, s, d, maxn);
        @(posedge clk); #1;
        bus.tgt_div_i   = 4'(t);
        bus.step_i      = 4'(s);
        bus.dwell_i     = 8'(d);
        bus.tgt_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.tgt_ready_o && n < 500) begin
            last_done = bus.done_o;
            @(negedge clk);
            n++;
        end
        if (!bus.tgt_ready_o) fail("req_timeout", n);
        after_done = last_done;
        @(posedge clk); #1;
        bus.tgt_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy_o && n < 3000);
        if (bus.busy_o) fail("idle_timeout", n);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail("hs_timeout", n);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.div_valid_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.div_valid_o) fail("valid_timeout", n);
    endtask

    task automatic end_ramp();
        wait_idle();
        chk("cur_final", int'(bus.cur_div_o), m_cur);
        chk("exp_left", exp_q.size(), 0);
        chk("done_left", exp_done.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                mon_cur    = DEF;
                low_cnt    = 0;
                prev_stall = 0;
                prev_done  = 0;
            end else begin
                exp_t e;
                chk("cur_div", int'(bus.cur_div_o), mon_cur);
                chk("ready_vs_busy", int'(bus.tgt_ready_o), int'(!bus.busy_o));
                if (prev_stall) begin
                    chk("stall_valid", int'(bus.div_valid_o), 1);
                    chk("stall_div", int'(bus.div_o), prev_div);
                end
                if (bus.div_valid_o && bus.div_ready_i) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_hs", int'(bus.div_o));
                    end else begin
                        e = exp_q.pop_front();
                        chk("div_step", int'(bus.div_o), e.v);
                        if (e.gap >= 0) chk("dwell_gap", low_cnt, e.gap);
                        mon_cur = e.v;
                    end
                    low_cnt = 0;
                end else if (!bus.div_valid_o) begin
                    low_cnt++;
                end
                prev_stall = bus.div_valid_o && !bus.div_ready_i;
                prev_div   = int'(bus.div_o);
                if (bus.done_o) begin
                    if (prev_done) fail("done_long", 1);
                    if (exp_done.size() == 0) fail("unexpected_done", int'(bus.cur_div_o));
                    else chk("done_cur", int'(bus.cur_div_o), exp_done.pop_front());
                end
                prev_done = bus.done_o;
            end
        end
    end

    initial begin
        bus.tgt_div_i   = '0;
        bus.step_i      = '0;
        bus.dwell_i     = '0;
        bus.tgt_valid_i = 1'b0;
        bus.abort_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.div_valid_o), 0);
        chk("rst_cur", int'(bus.cur_div_o), DEF);
        chk("rst_div", int'(bus.div_o), DEF);
        chk("rst_ready", int'(bus.tgt_ready_o), 1);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Up ramp 2 -> 10.
        req(10, 3, 4, 99, flag);
        end_ramp();

        // Down ramp with 5-cycle stall on every step.
        rdy_force = 1'b0;
        req(3, 4, 0, 99, flag);
        for (int k = 0; k < 2; k++) begin
            wait_valid();
            repeat (5) @(posedge clk);
            #1 rdy_force = 1'b1;
            @(posedge clk);
            #1 rdy_force = 1'b0;
        end
        rdy_force = 1'b1;
        end_ramp();

        // No-op request.
        req(3, 1, 0, 99, flag);
        chk("noop_done", int'(bus.done_o), 1);
        chk("noop_valid", int'(bus.div_valid_o), 0);
        end_ramp();

        // Clamps: zero target, zero step, top of range.
        req(0, 0, 0, 99, flag);
        end_ramp();
        req(4, 0, 1, 99, flag);
        end_ramp();
        req(14, 15, 0, 99, flag);
        end_ramp();
        req(15, 15, 2, 99, flag);
        end_ramp();

        // Abort while dwelling after the first step.
        req(1, 5, 6, 1, flag);
        wait_empty();
        @(posedge clk);
        @(posedge clk); #1;
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        chk("abort_dwell_busy", int'(bus.busy_o), 0);
        repeat (10) @(posedge clk);
        end_ramp();

        // Abort during a stalled issue.
        rdy_force = 1'b0;
        req(2, 3, 0, 1, flag);
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_force = 1'b1;
        end_ramp();
        repeat (5) @(posedge clk);
        chk("abort_issue_busy", int'(bus.busy_o), 0);

        // Reset in the middle of a stalled issue.
        req(12, 2, 3, 99, flag);
        while (exp_q.size() > 1) @(negedge clk);
        @(posedge clk);
        #1 rdy_force = 1'b0;
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_done.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", int'(bus.div_valid_o), 0);
        chk("mid_rst_cur", int'(bus.cur_div_o), DEF);
        chk("mid_rst_ready", int'(bus.tgt_ready_o), 1);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        m_cur = DEF;
        rdy_force = 1'b1;
        req(5, 2, 1, 99, flag);
        end_ramp();

        // Second request held off until the first ramp finishes.
        req(13, 3, 2, 99, flag);
        req(6, 7, 0, 99, flag);
        chk("held_after_done", int'(flag), 1);
        chk("held_busy", int'(bus.busy_o), 1);
        end_ramp();

        // Random ramps with random divider backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 99, flag);
            end_ramp();
        end
        rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
